uart_rx: RTL and testbench

//  UART receiver for the FTDI serial link: 8 data bits, LSB first, 1 start bit, 1 stop bit.

---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 start, 1 stop, mid-bit sampling, valid/ready output.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module uart_rx #(
    parameter int CYCLES_PER_BIT = 2604,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       ftdi_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       parity_err,
    output logic [7:0] led
);

    localparam int CW = $clog2(CYCLES_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_BIT = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CYCLES_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cycle_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   framing_err_q;
    logic                   overrun_q;
    logic                   rxs;
    logic                   bit_done;
`ifdef UART_RX_PARITY_EN
    logic                   parity_q;
    logic                   parity_err_q;
`endif

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign bit_done = (cycle_cnt_q == FULL_BIT);

    // Synchronizer flops preset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ftdi_rxd};
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q       <= IDLE;
            cycle_cnt_q   <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q      <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
            // A delivery later in this block overrides the acceptance, keeping rx_valid high.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cycle_cnt_q <= '0;
                    if (!rxs) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cycle_cnt_q == HALF_BIT) begin
                        cycle_cnt_q <= '0;
                        bit_cnt_q   <= '0;
                        state_q     <= rxs ? IDLE : DATA;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_q     <= {rxs, shift_q[7:1]};
                        cycle_cnt_q <= '0;
                        bit_cnt_q   <= bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
`else
                        if (bit_cnt_q == 3'd7) state_q <= STOP;
`endif
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        parity_q    <= rxs;
                        cycle_cnt_q <= '0;
                        state_q     <= STOP;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        cycle_cnt_q <= '0;
                        if (rxs) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            overrun_q  <= rx_valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= (parity_q != ^shift_q);
`endif
                            state_q    <= IDLE;
                        end else begin
                            framing_err_q <= 1'b1;
                            state_q       <= WAIT_IDLE;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign led         = rx_data_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of single frames plus hand-written overrun,
// glitch, break and mid-frame reset sequences. Honours UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PAR_EN ? 11 : 10;
    // Two sync stages, one IDLE detect cycle, half a bit to start-mid, then one bit per frame bit.
    localparam int LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rxReady = 1'b1;
    logic [7:0] rxData;
    logic       rxValid;
    logic       framingErr;
    logic       overrunP;
    logic       parityErr;
    logic [7:0] led;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int startCyc = 0;
    int validCycles = 0;
    int lastRiseCyc = 0;
    int framingCnt = 0;
    int overrunCnt = 0;
    int parityCnt = 0;
    int parityWithValid = 0;
    logic prevValid = 1'b0;

    uart_rx #(
        .CYCLES_PER_BIT(CPB),
        .SYNC_STAGES(2)
    ) dut (
        .clk_25mhz  (clk),
        .reset      (reset),
        .ftdi_rxd   (rxd),
        .rx_data    (rxData),
        .rx_valid   (rxValid),
        .rx_ready   (rxReady),
        .framing_err(framingErr),
        .overrun    (overrunP),
        .parity_err (parityErr),
        .led        (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor accumulates pulse counts on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rxValid) begin
            validCycles = validCycles + 1;
            if (!prevValid) lastRiseCyc = cyc;
        end
        prevValid = rxValid;
        if (framingErr) framingCnt = framingCnt + 1;
        if (overrunP) overrunCnt = overrunCnt + 1;
        if (parityErr) begin
            parityCnt = parityCnt + 1;
            if (rxValid) parityWithValid = parityWithValid + 1;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         stopBit;
        bit         badParity;
        int         expValid;
        int         expFraming;
        int         expParity;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic driveBit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input bit badParity);
        @(posedge clk);
        #1;
        startCyc = cyc;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
        if (PAR_EN) driveBit((^b) ^ badParity);
        driveBit(stopBit);
        rxd = 1'b1;
    endtask

    initial begin
        logic [7:0] expData;
        int v0, f0, o0, p0, pv0;
        expData = 8'h00;

        vecs[0] = '{8'h41, 1'b1, 1'b0, 1, 0, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1, 0, PAR_EN ? 1 : 0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 0, 1, 0};
        vecs[5] = '{8'h7E, 1'b1, 1'b0, 1, 0, 0};

        // Reset then long idle line: nothing delivered, all outputs at reset values.
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        idleCycles(100);
        @(negedge clk);
        checkOutput("reset_valid", 32'(rxValid), 32'd0);
        checkOutput("reset_data", 32'(rxData), 32'h00);
        checkOutput("reset_led", 32'(led), 32'h00);
        checkOutput("reset_flags", 32'(framingCnt + overrunCnt + parityCnt), 32'd0);

        // Table of single frames with rx_ready held high.
        for (int i = 0; i < 6; i++) begin
            v0 = validCycles; f0 = framingCnt; o0 = overrunCnt; p0 = parityCnt; pv0 = parityWithValid;
            applyStimulus(vecs[i].data, vecs[i].stopBit, vecs[i].badParity);
            idleCycles(20);
            @(negedge clk);
            if (vecs[i].expValid != 0) expData = vecs[i].data;
            $display("[TB] vector %0d data=%02h stop=%0d badpar=%0d", i, vecs[i].data, vecs[i].stopBit, vecs[i].badParity);
            checkOutput("vec_valid_cycles", 32'(validCycles - v0), 32'(vecs[i].expValid));
            checkOutput("vec_data", 32'(rxData), 32'(expData));
            checkOutput("vec_led", 32'(led), 32'(expData));
            checkOutput("vec_framing", 32'(framingCnt - f0), 32'(vecs[i].expFraming));
            checkOutput("vec_overrun", 32'(overrunCnt - o0), 32'd0);
            checkOutput("vec_parity", 32'(parityCnt - p0), 32'(vecs[i].expParity));
            checkOutput("vec_parity_with_valid", 32'(parityWithValid - pv0), 32'(vecs[i].expParity));
            if (vecs[i].expValid != 0)
                checkOutput("vec_latency", 32'(lastRiseCyc - startCyc), 32'(LAT));
        end

        // Back-to-back frames with consumer stalled: second delivery overruns.
        rxReady = 1'b0;
        o0 = overrunCnt;
        applyStimulus(8'h41, 1'b1, 1'b0);
        applyStimulus(8'h42, 1'b1, 1'b0);
        idleCycles(10);
        @(negedge clk);
        checkOutput("ovr_count", 32'(overrunCnt - o0), 32'd1);
        checkOutput("ovr_data", 32'(rxData), 32'h42);
        checkOutput("ovr_valid_held", 32'(rxValid), 32'd1);
        @(posedge clk);
        #1 rxReady = 1'b1;
        @(negedge clk);
        checkOutput("ovr_valid_before_edge", 32'(rxValid), 32'd1);
        @(negedge clk);
        checkOutput("ovr_valid_dropped", 32'(rxValid), 32'd0);
        expData = 8'h42;

        // Six-cycle low glitch must be rejected silently.
        v0 = validCycles; f0 = framingCnt; o0 = overrunCnt; p0 = parityCnt;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        idleCycles(40);
        @(negedge clk);
        checkOutput("glitch_valid", 32'(validCycles - v0), 32'd0);
        checkOutput("glitch_flags", 32'((framingCnt - f0) + (overrunCnt - o0) + (parityCnt - p0)), 32'd0);

        // Bad stop bit followed by a held-low break: exactly one framing error, then recovery.
        v0 = validCycles; f0 = framingCnt;
        applyStimulus(8'h5A, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idleCycles(30);
        @(negedge clk);
        checkOutput("break_framing", 32'(framingCnt - f0), 32'd1);
        checkOutput("break_valid", 32'(validCycles - v0), 32'd0);
        checkOutput("break_data_kept", 32'(rxData), 32'(expData));
        applyStimulus(8'h5B, 1'b1, 1'b0);
        idleCycles(20);
        @(negedge clk);
        checkOutput("after_break_data", 32'(rxData), 32'h5B);
        checkOutput("after_break_valid", 32'(validCycles - v0), 32'd1);
        checkOutput("after_break_framing", 32'(framingCnt - f0), 32'd1);

        // Reset in the middle of the data bits aborts the frame.
        v0 = validCycles;
        @(posedge clk);
        #1;
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b1);
        rxd = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_data", 32'(rxData), 32'h00);
        checkOutput("midreset_led", 32'(led), 32'h00);
        idleCycles(100);
        @(negedge clk);
        checkOutput("midreset_no_partial", 32'(validCycles - v0), 32'd0);
        applyStimulus(8'hC3, 1'b1, 1'b0);
        idleCycles(20);
        @(negedge clk);
        checkOutput("midreset_next_valid", 32'(validCycles - v0), 32'd1);
        checkOutput("midreset_next_data", 32'(rxData), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
